// File: rtl/ex_stage.sv
// Execute stage: ALU with control decode, branch-target adder, destination select,
// HI/LO registers and an iterative MULT/MULTU unit that stalls upstream while it runs.
module ex_stage #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       wb_ctl,
  input  logic [2:0]       m_ctl,
  input  logic [3:0]       ex_ctl,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] s_extend,
  input  logic [4:0]       instr_2016,
  input  logic [4:0]       instr_1511,
  output logic             stall,
  output logic [1:0]       wb_ctlout,
  output logic [2:0]       m_ctlout,
  output logic [WIDTH-1:0] add_result,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] rdata2out,
  output logic [4:0]       muxout
);

  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_n;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     hi, lo;
  logic [2*WIDTH-1:0]   mcand, acc, partial, acc_next, product;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;

  logic             regdst, alusrc;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_b, alu_res, mag1, mag2;
  logic             is_mul, is_signed, stall_c, last;

  assign regdst = ex_ctl[3];
  assign aluop  = ex_ctl[2:1];
  assign alusrc = ex_ctl[0];
  assign funct  = s_extend[5:0];
  assign op_b   = alusrc ? s_extend : rdata2;
  assign last   = (cnt == CW'(N - 1));

  always_comb begin
    alu_res   = '0;
    is_mul    = 1'b0;
    is_signed = 1'b0;
    case (aluop)
      2'b00: alu_res = rdata1 + op_b;
      2'b01: alu_res = rdata1 - op_b;
      2'b10: begin
        case (funct)
          6'b100000: alu_res = rdata1 + op_b;
          6'b100010: alu_res = rdata1 - op_b;
          6'b100100: alu_res = rdata1 & op_b;
          6'b100101: alu_res = rdata1 | op_b;
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rdata1) < $signed(op_b))};
          6'b010000: alu_res = hi;
          6'b010010: alu_res = lo;
          6'b011000: begin is_mul = 1'b1; is_signed = 1'b1; end
          6'b011001: is_mul = 1'b1;
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the sign is reapplied to the final product.
  assign mag1 = (is_signed && rdata1[WIDTH-1]) ? -rdata1 : rdata1;
  assign mag2 = (is_signed && rdata2[WIDTH-1]) ? -rdata2 : rdata2;

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++)
      if (mplier[i]) partial = partial + (mcand << i);
    acc_next = acc + partial;
    product  = neg ? -acc_next : acc_next;
  end

  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        stall_c = 1'b1;
        state_n = MUL;
      end
      MUL: begin
        if (last) state_n = IDLE;
        else      stall_c = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall = reset & stall_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (is_mul) begin
          mcand  <= {{WIDTH{1'b0}}, mag1};
          mplier <= mag2;
          acc    <= '0;
          neg    <= is_signed & (rdata1[WIDTH-1] ^ rdata2[WIDTH-1]);
          cnt    <= '0;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 1'b1;
          if (last) {hi, lo} <= product;
        end
        default: ;
      endcase

      if (stall_c) begin
        wb_ctlout  <= '0;
        m_ctlout   <= '0;
        add_result <= '0;
        zero       <= 1'b0;
        alu_result <= '0;
        rdata2out  <= '0;
        muxout     <= '0;
      end else begin
        wb_ctlout  <= wb_ctl;
        m_ctlout   <= m_ctl;
        add_result <= npc + (s_extend << 2);
        zero       <= (alu_res == '0);
        alu_result <= alu_res;
        rdata2out  <= rdata2;
        muxout     <= regdst ? instr_1511 : instr_2016;
      end
    end
  end

endmodule
